// File: rtl/data_setup_unit.sv
// data_setup_unit: streams a block of unified-buffer rows into the systolic
// array. Lane i of each row is delayed by i cycles to form the diagonal
// wavefront the array expects.
//
// Optional feature: define DSU_LANE_VALID_EN to add the lane_valid output,
// one bit per lane, high while that lane carries a real row element.
module data_setup_unit #(
  parameter int unsigned ADDRESSSIZE = 8,
  parameter int unsigned DATA_BW     = 8,
  parameter int unsigned MATRIX_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDRESSSIZE-1:0]         base_addr,
  input  logic [ADDRESSSIZE:0]           num_rows,
  output logic [ADDRESSSIZE-1:0]         sram_address,
  input  logic [MATRIX_SIZE*DATA_BW-1:0] sram_data_in,
  output logic [MATRIX_SIZE*DATA_BW-1:0] DIN,
  output logic                           busy,
  output logic                           done
`ifdef DSU_LANE_VALID_EN
  ,
  output logic [MATRIX_SIZE-1:0]         lane_valid
`endif
);

  localparam int unsigned RowW = ADDRESSSIZE + 1;
  localparam int unsigned CntW = $clog2(MATRIX_SIZE + 1) + 1;

  localparam logic [RowW-1:0]        RowOne    = RowW'(1);
  localparam logic [ADDRESSSIZE-1:0] AddrOne   = ADDRESSSIZE'(1);
  localparam logic [CntW-1:0]        CntOne    = CntW'(1);
  // Drain lasts MATRIX_SIZE+1 cycles: one for the read latency plus the
  // output register and the deepest skew stage.
  localparam logic [CntW-1:0]        DrainLast = CntW'(MATRIX_SIZE);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] addr_q, addr_d;
  logic [RowW-1:0]        rows_q, rows_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  // High in the cycle where sram_data_in holds a row requested by this block.
  logic                   rd_valid_q;

  // State, address and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rows_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rows_q     <= rows_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= (state_q == StRead);
    end
  end

  // Next-state logic: issue addresses in StRead, wait for the skew to empty
  // in StDrain, then pulse done for one cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rows_d  = rows_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_rows == '0) begin
            // Empty block: no reads, straight to the done pulse.
            state_d = StDone;
          end else begin
            state_d = StRead;
            addr_d  = base_addr;
            rows_d  = num_rows;
          end
        end
      end
      StRead: begin
        if (rows_q == RowOne) begin
          // Last address stays on the bus while draining.
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          rows_d = rows_q - RowOne;
          addr_d = addr_q + AddrOne;  // wraps modulo 2^ADDRESSSIZE
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign sram_address = addr_q;
  assign busy         = (state_q == StRead) || (state_q == StDrain);
  assign done         = (state_q == StDone);

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    logic [DATA_BW-1:0] skew_q [i+1];

    // Stage 0 registers the read word (zero when no row is valid); stages
    // 1..i add the diagonal delay for lane i.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          skew_q[j] <= '0;
        end
      end else begin
        skew_q[0] <= rd_valid_q ? sram_data_in[i*DATA_BW +: DATA_BW] : '0;
        for (int j = 1; j <= i; j++) begin
          skew_q[j] <= skew_q[j-1];
        end
      end
    end

    assign DIN[i*DATA_BW +: DATA_BW] = skew_q[i];
  end

`ifdef DSU_LANE_VALID_EN
  logic [MATRIX_SIZE-1:0] vld_q;

  // Valid shifts alongside the data so bit i lines up with lane i's skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_valid_q;
      for (int j = 1; j < MATRIX_SIZE; j++) begin
        vld_q[j] <= vld_q[j-1];
      end
    end
  end

  assign lane_valid = vld_q;
`endif

endmodule

// File: tb/tb_data_setup_unit.sv
// Self-checking bench for data_setup_unit with default parameters.
// Buffer model: word at address a has lane i = (a*16 + i) mod 256.
module tb_data_setup_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  num_rows;
  logic [7:0]  sram_address;
  logic [63:0] sram_data_in;
  logic [63:0] DIN;
  logic        busy;
  logic        done;
`ifdef DSU_LANE_VALID_EN
  logic [7:0]  lane_valid;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] last_addr;

  logic [7:0]  tr_addr [0:31];
  logic        tr_busy [0:31];
  logic        tr_done [0:31];
  logic [63:0] tr_din  [0:31];
`ifdef DSU_LANE_VALID_EN
  logic [7:0]  tr_lv   [0:31];
`endif

  typedef struct {
    logic [7:0] base;
    logic [8:0] n;
    int         exp_done;
    int         addr_cyc;
    logic [7:0] addr_val;
    int         spot_cyc;
    int         spot_lane;
    logic [7:0] spot_val;
  } vec_t;

  vec_t vecs [6];

  data_setup_unit #(
    .ADDRESSSIZE(8),
    .DATA_BW    (8),
    .MATRIX_SIZE(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .num_rows    (num_rows),
    .sram_address(sram_address),
    .sram_data_in(sram_data_in),
    .DIN         (DIN),
    .busy        (busy),
    .done        (done)
`ifdef DSU_LANE_VALID_EN
    ,
    .lane_valid  (lane_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lane_val(input logic [7:0] a, input int i);
    return 8'(int'(a) * 16 + i);
  endfunction

  // One-cycle synchronous-read buffer.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      sram_data_in[i*8 +: 8] <= lane_val(sram_address, i);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start a block in the next cycle (t0) and record cycles t0+1..t0+lim.
  // With spam set, start stays high with junk operands through the DONE cycle.
  task automatic run_block(input logic [7:0] b, input logic [8:0] n, input int lim,
                           input bit spam);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_rows = n;
    @(posedge clk); #1;
    if (spam) begin
      base_addr = 8'h99; num_rows = 9'd5;
    end else begin
      start = 1'b0;
    end
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      tr_addr[c] = sram_address;
      tr_busy[c] = busy;
      tr_done[c] = done;
      tr_din[c]  = DIN;
`ifdef DSU_LANE_VALID_EN
      tr_lv[c]   = lane_valid;
`endif
    end
    if (spam) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic check_block(input logic [7:0] b, input logic [8:0] n, input int exp_done,
                             input int lim);
    logic [63:0] exp_din;
    logic [7:0]  exp_lv;
    logic [7:0]  exp_addr;
    int          k;
    for (int c = 1; c <= lim; c++) begin
      chk($sformatf("busy b%0h c%0d", b, c), 64'(tr_busy[c]), 64'((n != 0) && (c < exp_done)));
      chk($sformatf("done b%0h c%0d", b, c), 64'(tr_done[c]), 64'(c == exp_done));
      if (n == 0) exp_addr = last_addr;
      else if (c <= int'(n)) exp_addr = b + 8'(c - 1);
      else exp_addr = b + 8'(int'(n) - 1);
      chk($sformatf("addr b%0h c%0d", b, c), 64'(tr_addr[c]), 64'(exp_addr));
      exp_din = '0;
      exp_lv  = '0;
      for (int i = 0; i < 8; i++) begin
        k = c - 3 - i;
        if (k >= 0 && k < int'(n)) begin
          exp_din[i*8 +: 8] = lane_val(b + 8'(k), i);
          exp_lv[i] = 1'b1;
        end
      end
      chk($sformatf("din b%0h c%0d", b, c), tr_din[c], exp_din);
`ifdef DSU_LANE_VALID_EN
      chk($sformatf("lane_valid b%0h c%0d", b, c), 64'(tr_lv[c]), 64'(exp_lv));
`endif
    end
    if (n != 0) last_addr = b + 8'(int'(n) - 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done, n_busy, n_din;
    //          base   rows   done addrc addrv  spotc lane spotv
    vecs[0] = '{8'h10, 9'd3,  13,  3,    8'h12, 12,   7,   8'h27};
    vecs[1] = '{8'hFE, 9'd4,  14,  3,    8'h00, 11,   5,   8'h15};
    vecs[2] = '{8'h40, 9'd0,  1,   1,    8'h01, 1,    0,   8'h00};
    vecs[3] = '{8'h00, 9'd1,  11,  1,    8'h00, 7,    4,   8'h04};
    vecs[4] = '{8'h33, 9'd8,  18,  8,    8'h3A, 17,   7,   8'hA7};
    vecs[5] = '{8'h70, 9'd2,  12,  2,    8'h71, 10,   6,   8'h16};

    rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
    last_addr = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset addr", 64'(sram_address), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    chk("reset din", DIN, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle din", DIN, 64'h0);
      chk("idle busy", 64'(busy), 64'h0);
    end

    // Table rows run back to back: each start lands in the first IDLE cycle.
    for (int v = 0; v < 6; v++) begin
      run_block(vecs[v].base, vecs[v].n, vecs[v].exp_done, 1'b0);
      check_block(vecs[v].base, vecs[v].n, vecs[v].exp_done, vecs[v].exp_done);
      chk($sformatf("spot addr v%0d", v), 64'(tr_addr[vecs[v].addr_cyc]),
          64'(vecs[v].addr_val));
      chk($sformatf("spot din v%0d", v),
          64'(tr_din[vecs[v].spot_cyc][vecs[v].spot_lane*8 +: 8]), 64'(vecs[v].spot_val));
    end

    // start held high while busy and through the DONE cycle must be ignored.
    run_block(8'h20, 9'd2, 12, 1'b1);
    check_block(8'h20, 9'd2, 12, 12);
    @(negedge clk);
    chk("after ignored start busy", 64'(busy), 64'h0);
    chk("after ignored start done", 64'(done), 64'h0);

    // Reset in cycle t0+5 of an 8-row block, with start asserted alongside.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h50; num_rows = 9'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy before reset", 64'(busy), 64'h1);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; base_addr = 8'h99; num_rows = 9'd5;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post-reset busy", 64'(busy), 64'h0);
    chk("post-reset done", 64'(done), 64'h0);
    chk("post-reset din", DIN, 64'h0);
    chk("post-reset addr", 64'(sram_address), 64'h0);
`ifdef DSU_LANE_VALID_EN
    chk("post-reset lane_valid", 64'(lane_valid), 64'h0);
`endif
    n_done = 0; n_busy = 0; n_din = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
      if (DIN != 64'h0) n_din++;
    end
    chk("dropped block done pulses", 64'(n_done), 64'h0);
    chk("dropped block busy cycles", 64'(n_busy), 64'h0);
    chk("dropped block din cycles", 64'(n_din), 64'h0);
    last_addr = 8'h00;

    // Fresh block after the reset keeps the nominal timing.
    run_block(8'h10, 9'd3, 13, 1'b0);
    check_block(8'h10, 9'd3, 13, 13);
    chk("fresh lane7 c12", 64'(tr_din[12][63:56]), 64'h27);
    chk("fresh done c13", 64'(tr_done[13]), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
